// File: rtl/writeback_unit_if.sv
// Issue, execute-result and register-file write signals of the writeback stage.
interface writeback_unit_if #(
    parameter int unsigned PE_COUNT       = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4
) ();
    logic                                 issue_valid;
    logic                                 issue_is_dot;
    logic [REG_ADDR_WIDTH-1:0]            issue_dst;
    logic                                 issue_ready;
    logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  elem_out;
    logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  dot_out;
    logic                                 wr_valid;
    logic                                 wr_ready;
    logic [REG_ADDR_WIDTH-1:0]            wr_addr;
    logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  wr_data;
    logic                                 busy;

    modport slave (
        input  issue_valid, issue_is_dot, issue_dst, elem_out, dot_out, wr_ready,
        output issue_ready, wr_valid, wr_addr, wr_data, busy
    );

    modport master (
        output issue_valid, issue_is_dot, issue_dst, elem_out, dot_out, wr_ready,
        input  issue_ready, wr_valid, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: tracks issued ops by tag, captures element/dot results when they
// complete and queues them (completion order) for credit-protected register-file writes.
module writeback_unit #(
    parameter int unsigned PE_COUNT       = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned DOT_LATENCY    = 3,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rstn,
    writeback_unit_if.slave  bus
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1) + 1;

    typedef logic [PE_COUNT-1:0][DATA_WIDTH-1:0] vec_t;

    typedef struct packed {
        logic                      valid;
        logic                      is_dot;
        logic [REG_ADDR_WIDTH-1:0] dst;
    } tag_t;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        vec_t                      data;
    } entry_t;

    tag_t            tags [DOT_LATENCY];
    entry_t          mem  [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   inflight_count;
    logic            ready_q;
    logic            valid_q;
    logic            busy_q;
    entry_t          head_q;

    logic            accept;
    logic            elem_done;
    logic            dot_done;
    logic            pop;
    logic [1:0]      n_push;
    entry_t          push_a;
    entry_t          push_b;
    logic [PW-1:0]   wr_ptr_nxt;
    logic [PW-1:0]   wr_ptr_p1;
    logic [PW-1:0]   rd_ptr_nxt;
    logic [CW-1:0]   remain;
    logic [CW-1:0]   fifo_nxt;
    logic [CW-1:0]   inflight_nxt;
    entry_t          head_nxt;
    logic            ready_nxt;

    assign bus.issue_ready = ready_q;
    assign bus.wr_valid    = valid_q;
    assign bus.busy        = busy_q;
    assign bus.wr_addr     = head_q.addr;
    assign bus.wr_data     = head_q.data;

    // Completion detection, queue bookkeeping and next values of the registered outputs.
    always_comb begin
        accept      = bus.issue_valid && ready_q;
        elem_done   = tags[0].valid && !tags[0].is_dot;
        dot_done    = tags[DOT_LATENCY-1].valid;
        pop         = valid_q && bus.wr_ready;
        n_push      = {1'b0, elem_done} + {1'b0, dot_done};

        // A dot finishing alongside an element takes the first slot.
        push_a.addr = dot_done ? tags[DOT_LATENCY-1].dst : tags[0].dst;
        push_a.data = dot_done ? bus.dot_out : bus.elem_out;
        push_b.addr = tags[0].dst;
        push_b.data = bus.elem_out;

        wr_ptr_nxt   = wr_ptr + PW'(n_push);
        wr_ptr_p1    = wr_ptr + PW'(1);
        rd_ptr_nxt   = rd_ptr + PW'(pop);
        remain       = fifo_count - CW'(pop);
        fifo_nxt     = remain + CW'(n_push);
        inflight_nxt = inflight_count + CW'(accept) - CW'(n_push);

        // Surviving old entries sit ahead of anything pushed this cycle.
        head_nxt = '0;
        if (remain != '0) begin
            head_nxt = mem[rd_ptr_nxt];
        end else if (n_push != 2'd0) begin
            head_nxt = push_a;
        end

        ready_nxt = (32'(inflight_nxt) + 32'(fifo_nxt) + 32'd1) <= FIFO_DEPTH;
    end

    // Tag pipeline, pointers, counters and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DOT_LATENCY; i++) begin
                tags[i] <= '0;
            end
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            inflight_count <= '0;
            ready_q        <= 1'b1;
            valid_q        <= 1'b0;
            busy_q         <= 1'b0;
            head_q         <= '0;
        end else begin
            tags[0].valid  <= accept;
            tags[0].is_dot <= bus.issue_is_dot;
            tags[0].dst    <= bus.issue_dst;
            // Element tags retire at stage 0; only dots travel further.
            tags[1].valid  <= tags[0].valid && tags[0].is_dot;
            tags[1].is_dot <= tags[0].is_dot;
            tags[1].dst    <= tags[0].dst;
            for (int i = 2; i < DOT_LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            fifo_count     <= fifo_nxt;
            inflight_count <= inflight_nxt;
            ready_q        <= ready_nxt;
            valid_q        <= (fifo_nxt != '0);
            busy_q         <= (fifo_nxt != '0) || (inflight_nxt != '0);
            head_q         <= head_nxt;
        end
    end

    // Queue storage; needs no reset since pointers and counts gate every read.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            mem[wr_ptr] <= push_a;
        end
        if (n_push == 2'd2) begin
            mem[wr_ptr_p1] <= push_b;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic against a
// completion-time reference model of pending ops and the expected write queue.
module tb_writeback_unit;
    localparam int unsigned PE = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned DL = 3;
    localparam int unsigned FD = 4;
    localparam int unsigned VW = PE * DW;

    typedef struct {
        int              done;
        bit              is_dot;
        logic [AW-1:0]   dst;
    } op_t;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [VW-1:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rstn;

    writeback_unit_if #(.PE_COUNT(PE), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

    writeback_unit #(
        .PE_COUNT(PE), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW),
        .DOT_LATENCY(DL), .FIFO_DEPTH(FD)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  n_acc  = 0;
    int  n_wr   = 0;
    op_t pend[$];
    wr_t exp_q[$];

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int l = 0; l < PE; l++) begin
            bus.elem_out[l] = DW'($urandom());
            bus.dot_out[l]  = DW'($urandom());
        end
    endtask

    // Compare outputs with the model, then advance the model across the coming edge.
    task automatic model_step();
        bit  m_ready;
        op_t keep[$];
        wr_t w;
        m_ready = (pend.size() + exp_q.size() + 1) <= FD;
        chk("issue_ready", VW'(bus.issue_ready), VW'(m_ready));
        chk("wr_valid", VW'(bus.wr_valid), VW'(exp_q.size() != 0));
        chk("busy", VW'(bus.busy), VW'((pend.size() + exp_q.size()) != 0));
        if (exp_q.size() != 0) begin
            chk("wr_addr", VW'(bus.wr_addr), VW'(exp_q[0].addr));
            chk("wr_data", VW'(bus.wr_data), exp_q[0].data);
        end
        if (bus.wr_valid && bus.wr_ready) n_wr++;
        if (!rstn) begin
            pend.delete();
            exp_q.delete();
            return;
        end
        if (exp_q.size() != 0 && bus.wr_ready) void'(exp_q.pop_front());
        for (int pass = 0; pass < 2; pass++) begin
            foreach (pend[i]) begin
                if (pend[i].done == cyc && pend[i].is_dot == (pass == 0)) begin
                    w.addr = pend[i].dst;
                    w.data = (pass == 0) ? VW'(bus.dot_out) : VW'(bus.elem_out);
                    exp_q.push_back(w);
                end
            end
        end
        foreach (pend[i]) if (pend[i].done != cyc) keep.push_back(pend[i]);
        pend = keep;
        if (bus.issue_valid && m_ready) begin
            pend.push_back('{cyc + (bus.issue_is_dot ? int'(DL) : 1), bus.issue_is_dot, bus.issue_dst});
            n_acc++;
        end
    endtask

    task automatic cycle(input logic v, input logic d, input logic [AW-1:0] dst, input logic rdy);
        bus.issue_valid  = v;
        bus.issue_is_dot = d;
        bus.issue_dst    = dst;
        bus.wr_ready     = rdy;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [VW-1:0] exp11;
        logic [VW-1:0] dot_a;
        logic [VW-1:0] elem_b;
        logic [AW-1:0] held_addr;
        logic [VW-1:0] held_data;

        rstn = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_is_dot = 1'b0;
        bus.issue_dst    = '0;
        bus.wr_ready     = 1'b0;
        rand_data();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_ready", VW'(bus.issue_ready), VW'(1));
        chk("rst_wr_valid", VW'(bus.wr_valid), VW'(0));
        chk("rst_busy", VW'(bus.busy), VW'(0));
        chk("rst_wr_addr", VW'(bus.wr_addr), VW'(0));
        chk("rst_wr_data", VW'(bus.wr_data), VW'(0));
        rstn = 1'b1;

        // Single element op
        rand_data();
        cycle(1'b1, 1'b0, AW'(5), 1'b1);
        for (int l = 0; l < PE; l++) bus.elem_out[l] = DW'(32'h11);
        exp11 = VW'(bus.elem_out);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("single_valid", VW'(bus.wr_valid), VW'(1));
        chk("single_addr", VW'(bus.wr_addr), VW'(5));
        chk("single_data", VW'(bus.wr_data), exp11);
        rand_data();
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("single_busy_low", VW'(bus.busy), VW'(0));
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b1);

        // Dot/element collision: dot enqueued first
        rand_data();
        cycle(1'b1, 1'b1, AW'(2), 1'b1);
        rand_data();
        cycle(1'b0, 1'b0, '0, 1'b1);
        rand_data();
        cycle(1'b1, 1'b0, AW'(7), 1'b1);
        rand_data();
        dot_a  = VW'(bus.dot_out);
        elem_b = VW'(bus.elem_out);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("coll_first_addr", VW'(bus.wr_addr), VW'(2));
        chk("coll_first_data", VW'(bus.wr_data), dot_a);
        rand_data();
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("coll_second_valid", VW'(bus.wr_valid), VW'(1));
        chk("coll_second_addr", VW'(bus.wr_addr), VW'(7));
        chk("coll_second_data", VW'(bus.wr_data), elem_b);
        repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);

        // Back-pressure with stall-ignore
        n_acc = 0;
        n_wr  = 0;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            cycle(1'b1, 1'b0, AW'(i + 1), 1'b0);
        end
        chk("bp_ready_low", VW'(bus.issue_ready), VW'(0));
        held_addr = bus.wr_addr;
        held_data = VW'(bus.wr_data);
        chk("bp_head_addr", VW'(held_addr), VW'(1));
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cycle(1'b1, 1'b1, AW'(9), 1'b0);
            chk("bp_hold_addr", VW'(bus.wr_addr), VW'(held_addr));
            chk("bp_hold_data", VW'(bus.wr_data), held_data);
        end
        chk("bp_stall_acc", VW'(n_acc), VW'(4));
        for (int i = 0; i < 4; i++) begin
            rand_data();
            cycle(1'b1, 1'b0, AW'(9), 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            rand_data();
            cycle(1'b0, 1'b0, '0, 1'b1);
        end
        chk("bp_write_count", VW'(n_wr), VW'(n_acc));

        // Reset mid-flight: one queued entry, two dots in flight
        rand_data();
        cycle(1'b1, 1'b0, AW'(3), 1'b0);
        rand_data();
        cycle(1'b1, 1'b1, AW'(4), 1'b0);
        rand_data();
        cycle(1'b1, 1'b1, AW'(6), 1'b0);
        chk("mid_busy", VW'(bus.busy), VW'(1));
        chk("mid_queued", VW'(bus.wr_valid), VW'(1));
        rstn = 1'b0;
        cycle(1'b0, 1'b0, '0, 1'b0);
        rstn = 1'b1;
        chk("mid_rst_ready", VW'(bus.issue_ready), VW'(1));
        chk("mid_rst_busy", VW'(bus.busy), VW'(0));
        chk("mid_rst_valid", VW'(bus.wr_valid), VW'(0));
        chk("mid_rst_addr", VW'(bus.wr_addr), VW'(0));
        chk("mid_rst_data", VW'(bus.wr_data), VW'(0));
        n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            cycle(1'b0, 1'b0, '0, 1'b1);
        end
        chk("mid_no_writes", VW'(n_wr), VW'(0));

        // Random traffic
        n_acc = 0;
        n_wr  = 0;
        for (int i = 0; i < 400; i++) begin
            rand_data();
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  AW'($urandom()), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 16; i++) begin
            rand_data();
            cycle(1'b0, 1'b0, '0, 1'b1);
        end
        chk("rand_write_count", VW'(n_wr), VW'(n_acc));
        chk("rand_idle_busy", VW'(bus.busy), VW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter PE_COUNT, default 4: lanes per vector.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bits per lane.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 4: vector register index width.
REQ-004 SHALL have parameter DOT_LATENCY, default 3: cycles from issue to valid dot result; legal range 2..8.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: write-queue entries; power of two, at least 2.
REQ-006 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-007 SHALL have port rstn, input, 1: reset; synchronous, active-low.
REQ-008 SHALL have port issue_valid, input, 1: an op is presented to the execute stage this cycle.
REQ-009 SHALL have port issue_is_dot, input, 1: the presented op is a dot product (1) or element-wise (0).
REQ-010 SHALL have port issue_dst, input, REG_ADDR_WIDTH: destination register of the presented op.
REQ-011 SHALL have port issue_ready, output, 1: the writeback stage can accept a new op this cycle.
REQ-012 SHALL have port elem_out, input, PE_COUNT x DATA_WIDTH: registered element-wise result.
REQ-013 SHALL have port dot_out, input, PE_COUNT x DATA_WIDTH: dot-product result.
REQ-014 SHALL have port wr_valid, output, 1: a register-file write is pending.
REQ-015 SHALL have port wr_ready, input, 1: the register file accepts the write.
REQ-016 SHALL have port wr_addr, output, REG_ADDR_WIDTH: write destination.
REQ-017 SHALL have port wr_data, output, PE_COUNT x DATA_WIDTH: write data.
REQ-018 SHALL have port busy, output, 1: ops in flight or queue non-empty.

Function
REQ-019 An issue is accepted in cycle T iff issue_valid && issue_ready in T; issue_valid with issue_ready low SHALL be ignored with no state change.
REQ-020 Each accepted issue SHALL create a tag {dst, is_dot} in a DOT_LATENCY-stage tag shift pipeline.
REQ-021 For an element tag issued in T, elem_out SHALL be sampled at the end of cycle T+1 and pushed with its dst.
REQ-022 For a dot tag issued in T, dot_out SHALL be sampled at the end of cycle T+DOT_LATENCY and pushed with its dst.
REQ-023 Two pushes SHALL be supported in one cycle; when a dot tag and an element tag complete together, the dot entry SHALL be enqueued first.
REQ-024 Queue output SHALL drive wr_valid = !empty, with wr_addr and wr_data taken from the head entry.
REQ-025 The head SHALL pop when wr_valid && wr_ready.
REQ-026 wr_addr and wr_data SHALL hold stable while wr_valid && !wr_ready.
REQ-027 A push into an empty queue SHALL make wr_valid high in the following cycle; there is no write-through.
REQ-028 Credit rule: issue_ready = (inflight_count + fifo_count + 1 <= FIFO_DEPTH), where inflight_count is the number of tags not yet pushed; overflow SHALL therefore be impossible.
REQ-029 issue_ready SHALL be computed from registered state only; it SHALL NOT depend on issue_valid or wr_ready in the same cycle.
REQ-030 Counter updates SHALL follow these rules:
- inflight_count: +1 per accepted issue, -1 per push.
- fifo_count: +pushes, -pops.
- Simultaneous issue, 2 pushes and a pop in one cycle SHALL net correctly.
REQ-031 The queue SHALL keep completion order: results are written in push order, which is not issue order when dots and elements interleave.
REQ-032 busy SHALL equal (inflight_count != 0) || (fifo_count != 0).

Reset
REQ-033 When rstn is low at a rising edge, the following SHALL be cleared:
- all tags invalid;
- inflight_count = 0 and fifo_count = 0;
- queue pointers = 0.
REQ-034 During and after reset the outputs SHALL be wr_valid = 0, busy = 0, issue_ready = 1, wr_addr = 0 and wr_data = 0.
REQ-035 Reset mid-operation SHALL discard all in-flight tags and queued entries; no write SHALL occur for them after reset.

Verification
REQ-036 Single element op: issue T=0 with dst=5 and elem_out=all lanes 0x11 at T=1, wr_ready=1 -> wr_valid at T=2, wr_addr=5, wr_data=0x11 per lane; busy low from T=3.
REQ-037 Collision: dot issued T=0 (dst=2), element issued T=2 (dst=7), DOT_LATENCY=3 -> both push at T=3; writes are dst 2 (T=4) then dst 7 (T=5).
REQ-038 Back-pressure: wr_ready=0 with 4 element ops issued -> issue_ready low after the 4th acceptance; wr_addr/wr_data stable; releasing wr_ready drains 4 writes in order.
REQ-039 Stall-ignore: issue_valid held high while issue_ready=0 -> no extra writes; the write count equals the number of accepted issues.
REQ-040 Reset mid-flight: 2 dots in flight plus 1 queued entry, rstn low 1 cycle -> no wr_valid afterwards; issue_ready=1 and busy=0.
